// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - M-stage data-memory controller arbitrating core and DMA onto one memory port.
// Optional wait-state timeout with sticky err is compiled in with DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_req,
  input  logic            core_we,
  input  logic [2:0]      core_funct3,
  input  logic [XLEN-1:0] core_addr,
  input  logic [XLEN-1:0] core_wdata,
  output logic [XLEN-1:0] core_rdata,
  output logic            core_stall,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [3:0]      dma_be,
  input  logic [XLEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  output logic [XLEN-1:0] dma_rdata,
  output logic            dma_done,
  output logic            mem_en,
  output logic [3:0]      mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, BUSY_CORE, BUSY_DMA} state_t;

  state_t     state;
  logic       dmaPrio;
  logic [2:0] funct3Q;
  logic [1:0] laneQ;
  logic       timeout;

  logic            isHalf, isWord, misaligned, coreOk;
  logic            grantCore, grantDma, busyDone;
  logic [3:0]      storeWe;
  logic [XLEN-1:0] storeData, loadData;
  logic [7:0]      rdByte;
  logic [15:0]     rdHalf;

  assign isHalf     = (core_funct3 == 3'b001) || (!core_we && core_funct3 == 3'b101);
  assign isWord     = (core_funct3 == 3'b010);
  assign misaligned = core_req && ((isHalf && core_addr[0]) || (isWord && core_addr[1:0] != 2'b00));
  assign coreOk     = core_req && !misaligned;

  // Priority bit only moves on contention; from reset the core wins the first tie.
  assign grantCore = (state == IDLE) && coreOk && (!dma_req || !dmaPrio);
  assign grantDma  = (state == IDLE) && dma_req && (!coreOk || dmaPrio);

`ifdef DMEM_TIMEOUT_EN
  logic [3:0] waitCnt;
  logic       errQ;
  assign timeout = (state != IDLE) && !mem_ready && (waitCnt == 4'(MAX_WAIT - 1));
  assign err     = errQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
      errQ    <= 1'b0;
    end else begin
      if (state == IDLE)
        waitCnt <= '0;
      else if (!mem_ready)
        waitCnt <= waitCnt + 4'd1;
      if (timeout)
        errQ <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busyDone = (state != IDLE) && (mem_ready || timeout);
  assign mem_en   = (state != IDLE);

  always_comb begin
    storeWe   = 4'b0000;
    storeData = core_wdata;
    case (core_funct3)
      3'b000: begin storeWe = 4'b0001 << core_addr[1:0]; storeData = {(XLEN/8){core_wdata[7:0]}}; end
      3'b001: begin storeWe = 4'b0011 << core_addr[1:0]; storeData = {(XLEN/16){core_wdata[15:0]}}; end
      3'b010: storeWe = 4'b1111;
      default: storeWe = 4'b0000;
    endcase
  end

  always_comb begin
    rdByte = mem_rdata[{laneQ, 3'b000} +: 8];
    rdHalf = mem_rdata[{laneQ[1], 4'b0000} +: 16];
    case (funct3Q)
      3'b000:  loadData = {{(XLEN-8){rdByte[7]}}, rdByte};
      3'b100:  loadData = {{(XLEN-8){1'b0}}, rdByte};
      3'b001:  loadData = {{(XLEN-16){rdHalf[15]}}, rdHalf};
      3'b101:  loadData = {{(XLEN-16){1'b0}}, rdHalf};
      3'b010:  loadData = mem_rdata;
      default: loadData = '0;
    endcase
  end

  assign core_rdata = (state == BUSY_CORE && mem_ready) ? loadData : '0;
  assign core_stall = core_req && !(state == BUSY_CORE && busyDone) && !misaligned;
  assign dma_done   = (state == BUSY_DMA) && busyDone;
  assign dma_rdata  = (state == BUSY_DMA && mem_ready) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dmaPrio   <= 1'b0;
      funct3Q   <= 3'b000;
      laneQ     <= 2'b00;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantCore) begin
            state     <= BUSY_CORE;
            funct3Q   <= core_funct3;
            laneQ     <= core_addr[1:0];
            mem_we    <= core_we ? storeWe : 4'b0000;
            mem_addr  <= {core_addr[XLEN-1:2], 2'b00};
            mem_wdata <= storeData;
            if (dma_req)
              dmaPrio <= 1'b1;
          end else if (grantDma) begin
            state     <= BUSY_DMA;
            mem_we    <= dma_we ? dma_be : 4'b0000;
            mem_addr  <= {dma_addr[XLEN-1:2], 2'b00};
            mem_wdata <= dma_wdata;
            if (coreOk)
              dmaPrio <= 1'b0;
          end
        end
        default: begin
          if (busyDone) begin
            state     <= IDLE;
            mem_we    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Memory-stage data-memory controller for the 3-stage core.
- Sits after the execute/memory pipeline register and shares one single-ported data memory between the core M-stage port and one DMA/debug requester.
- Generates byte enables and load formatting from funct3/address, and drives a stall that holds the execute/memory register until the core access completes.

Parameters:
- XLEN, 32, data/address width.
- MAX_WAIT, 15, timeout cycle limit; used only when DMEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- core_req  in  1  M-stage memory access valid (mem_accessM).
- core_we  in  1  1=store, 0=load.
- core_funct3  in  3  access size/sign (RV32I load/store encoding).
- core_addr  in  XLEN  byte address (alu_outM).
- core_wdata  in  XLEN  store data (forwarded rs2M).
- core_rdata  out  XLEN  formatted load data, valid when core_stall=0 and core_req=1.
- core_stall  out  1  hold execute/memory register and upstream stages.
- dma_req  in  1  DMA request, held until dma_done.
- dma_we  in  1  DMA write.
- dma_be  in  4  DMA byte enables.
- dma_addr  in  XLEN  DMA word address.
- dma_wdata  in  XLEN  DMA write data.
- dma_rdata  out  XLEN  DMA read data, valid with dma_done.
- dma_done  out  1  one-cycle completion pulse.
- mem_en  out  1  memory request.
- mem_we  out  4  byte write enables.
- mem_addr  out  XLEN  word-aligned address (bits [1:0]=0).
- mem_wdata  out  XLEN  lane-aligned write data.
- mem_rdata  in  XLEN  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.
- err  out  1  sticky timeout flag (DMEM_TIMEOUT_EN only, else tied 0).

Behaviour:
- FSM states: IDLE, BUSY_CORE, BUSY_DMA. Reset: state=IDLE, last_gnt=0 (core); all outputs 0 except core_stall, which follows its combinational rule.
- IDLE: core_req alone -> BUSY_CORE. dma_req alone -> BUSY_DMA. Both -> grant the requester not equal to last_gnt, then update last_gnt. Neither -> stay IDLE.
- BUSY_x: mem_en=1; mem_addr/mem_we/mem_wdata are held constant from that requester's inputs until mem_ready=1. On mem_ready -> IDLE.
- Minimum latency is 2 cycles (IDLE + one BUSY cycle). There is no direct BUSY->BUSY transition.
- core_stall = core_req & !(state==BUSY_CORE & mem_ready) & !misaligned_core.
- core_rdata is combinational from mem_rdata in the completion cycle; it is 0 otherwise.
- dma_done=1 and dma_rdata=mem_rdata in the BUSY_DMA cycle where mem_ready=1.
- Stores (core): funct3 000 SB -> we=0001<<addr[1:0], byte replicated to all lanes. 001 SH -> we=0011<<addr[1:0], halfword replicated. 010 SW -> we=1111. Other funct3 values -> we=0000.
- Loads (core): mem_we=0000. Lane select by addr[1:0].
  - 000 LB / 100 LBU: sign-/zero-extend the selected byte.
  - 001 LH / 101 LHU: sign-/zero-extend the selected halfword.
  - 010 LW: full word.
  - Other funct3 values: return 0.
- Misaligned core access: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No grant and no memory access; mem_en stays 0.
  - core_rdata=0, core_stall=0 (completes immediately, store dropped).
- DMA: mem_we = dma_we ? dma_be : 0000; mem_addr = {dma_addr[XLEN-1:2],2'b00}.
- core_req deasserting in BUSY_CORE does not occur: the pipeline is stalled. The access completes regardless.
- A DMA request arriving during BUSY_CORE waits. The next arbitration favours DMA because last_gnt=core.
- rst asserted mid-access: FSM -> IDLE immediately, mem_en drops the same cycle asynchronously, the in-flight access is abandoned, and no done pulse is issued.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on entry to BUSY_x and increments each BUSY cycle without mem_ready.
  - On reaching MAX_WAIT: abort to IDLE, set err (sticky until rst), and complete the access. For core: core_stall=0, rdata=0. For DMA: dma_done=1, rdata=0.
- Not defined: no counter; BUSY waits indefinitely; err tied 0.

Test Plan:
- mem_ready tied 1, core LW at addr 0x100 with mem_rdata=0xDEADBEEF -> core_stall=1 for 1 cycle, then core_rdata=0xDEADBEEF and stall=0 in cycle 2.
- Core SB addr 0x103, wdata 0x000000A5 -> mem_we=1000, mem_addr=0x100, mem_wdata=0xA5A5A5A5.
- Core LB addr 0x102 with mem_rdata=0x0080FF00 -> core_rdata=0xFFFFFF80. Same access as LBU -> 0x00000080.
- core_req and dma_req asserted together from reset -> core granted first, DMA next. Second simultaneous pair -> DMA granted first.
- Core LH at addr 0x101 -> mem_en stays 0, core_stall=0, core_rdata=0.
- DMEM_TIMEOUT_EN with mem_ready held 0 on a DMA read -> dma_done pulses after 15 BUSY cycles with rdata=0, err=1 until rst. rst asserted during BUSY -> mem_en=0 immediately.
